// File: rtl/inst_sram_fetch_ctrl_pkg.sv
// Shared fetch-path types and constants for the uncached instruction bus controller.
package inst_sram_fetch_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    REQ      = 3'd1,
    WAIT     = 3'd2,
    HOLD     = 3'd3,
    REQ_DROP = 3'd4,
    DROP     = 3'd5
  } fetch_state_t;

  localparam logic [1:0]  BUS_SIZE_WORD = 2'b10;
  localparam logic [31:0] RESET_PC      = 32'hbfc00000;

endpackage

// File: rtl/inst_sram_fetch_ctrl.sv
// Single-outstanding SRAM-like instruction fetch controller feeding the I stage.
// Stale responses after a flush are drained in REQ_DROP/DROP and never reach inst_valid.
//
// Handshake: bus_req is held with a stable bus_addr until bus_addr_ok is seen
// in the same cycle; bus_data_ok is only sampled in WAIT/DROP. inst_valid stays
// high with unchanged inst_data/inst_pc until a cycle with advance or flush.
module inst_sram_fetch_ctrl
  import inst_sram_fetch_ctrl_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] fetch_pc,
  input  logic              fetch_en,
  input  logic              flush,
  input  logic              advance,
  output logic              inst_valid,
  output logic [DATA_W-1:0] inst_data,
  output logic [ADDR_W-1:0] inst_pc,
  output logic              bus_req,
  output logic              bus_wr,
  output logic [1:0]        bus_size,
  output logic [ADDR_W-1:0] bus_addr,
  input  logic              bus_addr_ok,
  input  logic              bus_data_ok,
  input  logic [DATA_W-1:0] bus_rdata,
  output fetch_state_t      dbg_state
);

  fetch_state_t state;

  assign bus_wr    = 1'b0;
  assign bus_size  = BUS_SIZE_WORD;
  assign dbg_state = state;

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      inst_valid <= 1'b0;
      inst_data  <= '0;
      inst_pc    <= '0;
      bus_req    <= 1'b0;
      bus_addr   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (fetch_en && !flush) begin
            bus_addr <= fetch_pc;
            bus_req  <= 1'b1;
            state    <= REQ;
          end
        end
        REQ: begin
          if (bus_addr_ok) begin
            bus_req <= 1'b0;
            state   <= flush ? DROP : WAIT;
          end else if (flush) begin
            state <= REQ_DROP;
          end
        end
        // Request already on the bus cannot be withdrawn; wait for acceptance.
        REQ_DROP: begin
          if (bus_addr_ok) begin
            bus_req <= 1'b0;
            state   <= DROP;
          end
        end
        WAIT: begin
          if (bus_data_ok) begin
            if (flush) begin
              state <= IDLE;
            end else begin
              inst_data  <= bus_rdata;
              inst_pc    <= bus_addr;
              inst_valid <= 1'b1;
              state      <= HOLD;
            end
          end else if (flush) begin
            state <= DROP;
          end
        end
        DROP: begin
          if (bus_data_ok) state <= IDLE;
        end
        HOLD: begin
          if (flush) begin
            inst_valid <= 1'b0;
            state      <= IDLE;
          end else if (advance) begin
            inst_valid <= 1'b0;
            // Issue the next fetch directly to avoid an IDLE bubble.
            if (fetch_en) begin
              bus_addr <= fetch_pc;
              bus_req  <= 1'b1;
              state    <= REQ;
            end else begin
              state <= IDLE;
            end
          end
        end
        default: begin
          bus_req    <= 1'b0;
          inst_valid <= 1'b0;
          state      <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_inst_sram_fetch_ctrl.sv
// Directed bench for inst_sram_fetch_ctrl: expected words queued at issue,
// a negedge monitor pops and compares each newly presented instruction.
module tb_inst_sram_fetch_ctrl;
  import inst_sram_fetch_ctrl_pkg::*;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;

  logic              clk;
  logic              reset;
  logic [ADDR_W-1:0] fetch_pc;
  logic              fetch_en;
  logic              flush;
  logic              advance;
  logic              inst_valid;
  logic [DATA_W-1:0] inst_data;
  logic [ADDR_W-1:0] inst_pc;
  logic              bus_req;
  logic              bus_wr;
  logic [1:0]        bus_size;
  logic [ADDR_W-1:0] bus_addr;
  logic              bus_addr_ok;
  logic              bus_data_ok;
  logic [DATA_W-1:0] bus_rdata;
  fetch_state_t      dbg_state;

  int n_checks = 0;
  int n_fail   = 0;

  // {pc, data} of each instruction the I stage should see, in order
  logic [ADDR_W+DATA_W-1:0] exp_q[$];

  inst_sram_fetch_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk(clk), .reset(reset), .fetch_pc(fetch_pc), .fetch_en(fetch_en),
    .flush(flush), .advance(advance), .inst_valid(inst_valid),
    .inst_data(inst_data), .inst_pc(inst_pc), .bus_req(bus_req),
    .bus_wr(bus_wr), .bus_size(bus_size), .bus_addr(bus_addr),
    .bus_addr_ok(bus_addr_ok), .bus_data_ok(bus_data_ok),
    .bus_rdata(bus_rdata), .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- checking ----------------
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  logic prev_valid = 1'b0;
  always @(negedge clk) begin
    if (reset) begin
      prev_valid <= 1'b0;
    end else begin
      if (inst_valid && !prev_valid) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_valid: got pc %h data %h, none expected", inst_pc, inst_data);
        end else begin
          logic [63:0] e;
          e = exp_q.pop_front();
          check("mon_inst_pc", 64'(inst_pc), 64'(e[63:32]));
          check("mon_inst_data", 64'(inst_data), 64'(e[31:0]));
        end
      end
      prev_valid <= inst_valid;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    fetch_en    = 1'b0;
    flush       = 1'b0;
    advance     = 1'b0;
    bus_addr_ok = 1'b0;
    bus_data_ok = 1'b0;
  endtask

  // Full fetch from IDLE: addr_ok on first REQ cycle, data_ok in the next cycle.
  task automatic fetch_word(input logic [31:0] pc, input logic [31:0] data);
    fetch_pc = pc;
    fetch_en = 1'b1;
    tick();
    fetch_en    = 1'b0;
    bus_addr_ok = 1'b1;
    tick();
    bus_addr_ok = 1'b0;
    bus_data_ok = 1'b1;
    bus_rdata   = data;
    exp_q.push_back({pc, data});
    tick();
    bus_data_ok = 1'b0;
  endtask

  task automatic consume();
    advance = 1'b1;
    tick();
    advance = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    reset = 1'b1;
    fetch_pc = '0;
    bus_rdata = '0;
    idle_inputs();
    repeat (3) tick();
    reset = 1'b0;
    tick();

    check("rst_state", 64'(dbg_state), 64'(IDLE));
    check("rst_inst_valid", 64'(inst_valid), 64'd0);
    check("rst_inst_data", 64'(inst_data), 64'd0);
    check("rst_inst_pc", 64'(inst_pc), 64'd0);
    check("rst_bus_req", 64'(bus_req), 64'd0);
    check("rst_bus_addr", 64'(bus_addr), 64'd0);
    check("bus_wr", 64'(bus_wr), 64'd0);
    check("bus_size", 64'(bus_size), 64'h2);

    // Single fetch: addr_ok in cycle 1, data_ok in cycle 3, valid in cycle 4
    fetch_pc = 32'hbfc00000;
    fetch_en = 1'b1;
    tick();
    fetch_en = 1'b0;
    check("t1_bus_req", 64'(bus_req), 64'd1);
    check("t1_bus_addr", 64'(bus_addr), 64'hbfc00000);
    bus_addr_ok = 1'b1;
    tick();
    bus_addr_ok = 1'b0;
    check("t1_req_drop", 64'(bus_req), 64'd0);
    tick();
    check("t1_not_valid", 64'(inst_valid), 64'd0);
    bus_data_ok = 1'b1;
    bus_rdata   = 32'h3c080001;
    exp_q.push_back({32'hbfc00000, 32'h3c080001});
    tick();
    bus_data_ok = 1'b0;
    check("t1_valid", 64'(inst_valid), 64'd1);

    // Back-to-back: advance with fetch_en issues next request without bubble
    advance  = 1'b1;
    fetch_en = 1'b1;
    fetch_pc = 32'hbfc00004;
    tick();
    advance  = 1'b0;
    fetch_en = 1'b0;
    check("t2_bus_req", 64'(bus_req), 64'd1);
    check("t2_bus_addr", 64'(bus_addr), 64'hbfc00004);
    check("t2_valid_low", 64'(inst_valid), 64'd0);
    check("t2_state", 64'(dbg_state), 64'(REQ));
    bus_addr_ok = 1'b1;
    tick();
    bus_addr_ok = 1'b0;
    bus_data_ok = 1'b1;
    bus_rdata   = 32'h24090002;
    exp_q.push_back({32'hbfc00004, 32'h24090002});
    tick();
    bus_data_ok = 1'b0;
    consume();
    check("t2_idle", 64'(dbg_state), 64'(IDLE));

    // Flush in WAIT, stale data 2 cycles later is discarded
    fetch_pc = 32'h80000100;
    fetch_en = 1'b1;
    tick();
    fetch_en    = 1'b0;
    bus_addr_ok = 1'b1;
    tick();
    bus_addr_ok = 1'b0;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("t3_drop", 64'(dbg_state), 64'(DROP));
    tick();
    bus_data_ok = 1'b1;
    bus_rdata   = 32'hdeadbeef;
    tick();
    bus_data_ok = 1'b0;
    check("t3_state_idle", 64'(dbg_state), 64'(IDLE));
    check("t3_valid_low", 64'(inst_valid), 64'd0);
    fetch_word(32'h80000180, 32'h40806000);
    check("t3_refetch_valid", 64'(inst_valid), 64'd1);
    consume();

    // Flush in REQ, addr_ok delayed 3 cycles; fetch_pc wanders meanwhile
    fetch_pc = 32'h80000200;
    fetch_en = 1'b1;
    tick();
    fetch_en = 1'b0;
    flush    = 1'b1;
    tick();
    flush = 1'b0;
    for (int i = 0; i < 3; i++) begin
      fetch_pc = 32'h90000000 + 32'(i * 4);
      tick();
      check("t4_req_held", 64'(bus_req), 64'd1);
      check("t4_addr_stable", 64'(bus_addr), 64'h80000200);
    end
    bus_addr_ok = 1'b1;
    tick();
    bus_addr_ok = 1'b0;
    check("t4_req_off", 64'(bus_req), 64'd0);
    bus_data_ok = 1'b1;
    bus_rdata   = 32'h11111111;
    tick();
    bus_data_ok = 1'b0;
    check("t4_state_idle", 64'(dbg_state), 64'(IDLE));
    check("t4_valid_low", 64'(inst_valid), 64'd0);

    // Stall hold: word held for 5 cycles with fetch_pc toggling
    fetch_word(32'h80000300, 32'haabbccdd);
    fetch_en = 1'b1;
    for (int i = 0; i < 5; i++) begin
      fetch_pc = (i % 2 == 0) ? 32'h12345678 : 32'h87654320;
      tick();
      check("t5_valid", 64'(inst_valid), 64'd1);
      check("t5_data", 64'(inst_data), 64'haabbccdd);
      check("t5_pc", 64'(inst_pc), 64'h80000300);
      check("t5_bus_req", 64'(bus_req), 64'd0);
    end
    fetch_en = 1'b0;
    consume();

    // addr_ok together with flush in REQ goes to DROP
    fetch_pc = 32'h80000400;
    fetch_en = 1'b1;
    tick();
    fetch_en    = 1'b0;
    bus_addr_ok = 1'b1;
    flush       = 1'b1;
    tick();
    bus_addr_ok = 1'b0;
    flush       = 1'b0;
    check("t6_drop", 64'(dbg_state), 64'(DROP));
    bus_data_ok = 1'b1;
    bus_rdata   = 32'h22222222;
    tick();
    bus_data_ok = 1'b0;
    check("t6_idle", 64'(dbg_state), 64'(IDLE));

    // data_ok and flush together in WAIT: data discarded, back to IDLE
    fetch_pc = 32'h80000500;
    fetch_en = 1'b1;
    tick();
    fetch_en    = 1'b0;
    bus_addr_ok = 1'b1;
    tick();
    bus_addr_ok = 1'b0;
    bus_data_ok = 1'b1;
    flush       = 1'b1;
    bus_rdata   = 32'h33333333;
    tick();
    bus_data_ok = 1'b0;
    flush       = 1'b0;
    check("t7_idle", 64'(dbg_state), 64'(IDLE));
    check("t7_valid_low", 64'(inst_valid), 64'd0);

    // Flush while holding drops the word
    fetch_word(32'h80000600, 32'h44444444);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("t8_valid_low", 64'(inst_valid), 64'd0);
    check("t8_idle", 64'(dbg_state), 64'(IDLE));

    // Reset in WAIT, then a late data_ok is ignored
    fetch_pc = 32'h80000700;
    fetch_en = 1'b1;
    tick();
    fetch_en    = 1'b0;
    bus_addr_ok = 1'b1;
    tick();
    bus_addr_ok = 1'b0;
    reset = 1'b1;
    tick();
    reset       = 1'b0;
    bus_data_ok = 1'b1;
    bus_rdata   = 32'h55555555;
    tick();
    bus_data_ok = 1'b0;
    tick();
    check("t9_state", 64'(dbg_state), 64'(IDLE));
    check("t9_valid", 64'(inst_valid), 64'd0);
    check("t9_bus_req", 64'(bus_req), 64'd0);
    check("t9_bus_addr", 64'(bus_addr), 64'd0);
    check("t9_inst_data", 64'(inst_data), 64'd0);
    check("t9_inst_pc", 64'(inst_pc), 64'd0);

    repeat (2) tick();
    check("scoreboard_drained", 64'(exp_q.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
